// File: rtl/fpu_issue_ctrl.sv
// Issue controller for the shared multi-cycle FPU: accepts one op, holds its
// operands at the datapath for the op's fixed latency, then returns the result.
module fpu_issue_ctrl #(
   parameter int unsigned LAT_ADD  = 2,
   parameter int unsigned LAT_MUL  = 1,
   parameter int unsigned LAT_DIV  = 10,
   parameter int unsigned LAT_SQRT = 10,
   parameter int unsigned LAT_CVT  = 1,
   parameter int unsigned DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [DATA_W-1:0] req_x1,
   input  logic [DATA_W-1:0] req_x2,
   input  logic [4:0]        req_rd,
   output logic [3:0]        fpu_op,
   output logic [DATA_W-1:0] fpu_x1,
   output logic [DATA_W-1:0] fpu_x2,
   input  logic [DATA_W-1:0] fpu_y,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [4:0]        resp_rd,
   output logic              resp_err,
   output logic              busy,
   input  logic              flush
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            r_state;
   logic [4:0]        r_cnt;
   logic [3:0]        r_op;
   logic [DATA_W-1:0] r_x1;
   logic [DATA_W-1:0] r_x2;
   logic [4:0]        r_rd;
   logic              r_resp_valid;
   logic [DATA_W-1:0] r_resp_data;
   logic [4:0]        r_resp_rd;
   logic              r_resp_err;

   logic [4:0]        w_lat;
   logic              w_illegal;
   logic              w_idle;

   function automatic logic [4:0] f_lat(input logic [3:0] op);
      case (op)
         4'd0, 4'd1:   return 5'(LAT_ADD);
         4'd2:         return 5'(LAT_MUL);
         4'd3:         return 5'(LAT_DIV);
         4'd4:         return 5'(LAT_SQRT);
         4'd11, 4'd12: return 5'(LAT_CVT);
         default:      return 5'd0;
      endcase
   endfunction

   assign w_lat     = f_lat(req_op);
   assign w_illegal = (req_op >= 4'd13);
   assign w_idle    = (r_state == S_IDLE);

   // In IDLE the datapath sees the offered op directly so zero-latency ops
   // can be captured on the accept edge.
   assign fpu_op     = w_idle ? req_op : r_op;
   assign fpu_x1     = w_idle ? req_x1 : r_x1;
   assign fpu_x2     = w_idle ? req_x2 : r_x2;

   assign req_ready  = w_idle & ~flush;
   assign busy       = ~w_idle;
   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;
   assign resp_rd    = r_resp_rd;
   assign resp_err   = r_resp_err;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_cnt        <= 5'd0;
         r_op         <= 4'd0;
         r_x1         <= '0;
         r_x2         <= '0;
         r_rd         <= 5'd0;
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
         r_resp_rd    <= 5'd0;
         r_resp_err   <= 1'b0;
      end else if (flush) begin
         r_state      <= S_IDLE;
         r_cnt        <= 5'd0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_op <= req_op;
                  r_x1 <= req_x1;
                  r_x2 <= req_x2;
                  r_rd <= req_rd;
                  if (w_illegal || w_lat == 5'd0) begin
                     r_resp_valid <= 1'b1;
                     r_resp_data  <= w_illegal ? '0 : fpu_y;
                     r_resp_rd    <= req_rd;
                     r_resp_err   <= w_illegal;
                     r_state      <= S_DONE;
                  end else begin
                     r_cnt   <= w_lat;
                     r_state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               // Exit at 1 so the counter never wraps below zero.
               if (r_cnt == 5'd1) begin
                  r_resp_valid <= 1'b1;
                  r_resp_data  <= fpu_y;
                  r_resp_rd    <= r_rd;
                  r_state      <= S_DONE;
               end
               r_cnt <= r_cnt - 5'd1;
            end
            S_DONE: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_resp_err   <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: a fake FPU, a transaction-level reference model and
// scoreboard, table-driven latency vectors, directed corner cases and random traffic.
module tb_fpu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_x1, req_x2;
   logic [4:0]  req_rd;
   logic [3:0]  fpu_op;
   logic [31:0] fpu_x1, fpu_x2, fpu_y;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_err, busy, flush;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fpu_issue_ctrl dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_x1(req_x1), .req_x2(req_x2), .req_rd(req_rd),
      .fpu_op(fpu_op), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_y(fpu_y),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_rd(resp_rd), .resp_err(resp_err), .busy(busy), .flush(flush)
   );

   // Stand-in FPU: a deterministic function of its inputs, with real answers
   // for the fadd and feq cases used by the directed tests.
   function automatic logic [31:0] fake_y(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op == 4'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
      if (op == 4'd8) return {31'd0, a == b};
      return (a ^ {b[15:0], b[31:16]}) + ({28'd0, op} * 32'h01010101) + 32'h9E3779B9;
   endfunction

   assign fpu_y = fake_y(fpu_op, fpu_x1, fpu_x2);

   int lat_tab [16] = '{2, 2, 1, 10, 10, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        err;
   } resp_t;

   resp_t       sb_q[$];
   int          m_wait;
   bit          m_valid, m_err;
   logic [31:0] m_data;
   logic [4:0]  m_rd;
   logic [3:0]  p_op;
   logic [31:0] p_x1, p_x2;
   logic [4:0]  p_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_wait = 0; m_valid = 0; m_err = 0; m_data = '0; m_rd = '0;
      p_op = '0; p_x1 = '0; p_x2 = '0; p_rd = '0;
      sb_q.delete();
   endtask

   // Advance model and DUT by one clock; inputs must already be set.
   task automatic step();
      int    n;
      resp_t r;
      if (!flush && resp_valid && resp_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_resp", {31'd0, resp_valid}, 32'd0);
         end else begin
            r = sb_q.pop_front();
            chk("sb_data", resp_data, r.data);
            chk("sb_rd", {27'd0, resp_rd}, {27'd0, r.rd});
            chk("sb_err", {31'd0, resp_err}, {31'd0, r.err});
         end
      end
      if (flush) begin
         m_wait = 0; m_valid = 0; m_err = 0;
         sb_q.delete();
      end else if (m_valid) begin
         if (resp_ready) begin m_valid = 0; m_err = 0; end
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) begin
            m_valid = 1; m_data = fake_y(p_op, p_x1, p_x2); m_rd = p_rd;
         end
      end else if (req_valid) begin
         p_op = req_op; p_x1 = req_x1; p_x2 = req_x2; p_rd = req_rd;
         n = lat_tab[req_op];
         r.rd = req_rd;
         r.err = (req_op >= 4'd13);
         r.data = r.err ? 32'd0 : fake_y(req_op, req_x1, req_x2);
         sb_q.push_back(r);
         if (r.err || n == 0) begin
            m_valid = 1; m_data = r.data; m_rd = r.rd; m_err = r.err;
         end else begin
            m_wait = n;
         end
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic compare_all();
      bit idle;
      idle = (m_wait == 0) && !m_valid;
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_valid});
      chk("busy", {31'd0, busy}, {31'd0, !idle});
      chk("req_ready", {31'd0, req_ready}, {31'd0, idle && !flush});
      chk("ready_while_busy", {31'd0, req_ready & busy}, 32'd0);
      chk("resp_data", resp_data, m_data);
      chk("resp_rd", {27'd0, resp_rd}, {27'd0, m_rd});
      chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
      chk("fpu_op", {28'd0, fpu_op}, {28'd0, idle ? req_op : p_op});
      chk("fpu_x1", fpu_x1, idle ? req_x1 : p_x1);
      chk("fpu_x2", fpu_x2, idle ? req_x2 : p_x2);
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      req_valid = 1'b1; req_op = op; req_x1 = a; req_x2 = b; req_rd = rd;
   endtask

   task automatic handshake();
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] x1, x2;
      logic [4:0]  rd;
      int          exp_lat;
      logic        exp_err;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int lat;
      logic [31:0] exp_d;

      vecs[0] = '{4'd1,  32'h11112222, 32'h33334444, 5'd1,  2,  1'b0};
      vecs[1] = '{4'd2,  32'hDEADBEEF, 32'h00000003, 5'd2,  1,  1'b0};
      vecs[2] = '{4'd4,  32'h40800000, 32'h00000000, 5'd4,  10, 1'b0};
      vecs[3] = '{4'd5,  32'h80000001, 32'h7FFFFFFF, 5'd6,  0,  1'b0};
      vecs[4] = '{4'd10, 32'h00000010, 32'h00000020, 5'd8,  0,  1'b0};
      vecs[5] = '{4'd11, 32'h4F000000, 32'h00000000, 5'd10, 1,  1'b0};
      vecs[6] = '{4'd12, 32'hFFFFFFFF, 32'h00000001, 5'd31, 1,  1'b0};
      vecs[7] = '{4'd15, 32'h12345678, 32'h9ABCDEF0, 5'd17, 0,  1'b1};

      rstn = 1'b0; req_valid = 1'b0; req_op = '0; req_x1 = '0; req_x2 = '0;
      req_rd = '0; resp_ready = 1'b0; flush = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rstn = 1'b1;

      // fadd: 2-cycle latency with operand hold
      drive(4'd0, 32'h3F800000, 32'h40000000, 5'd5);
      step();
      drive(4'd7, 32'hAAAAAAAA, 32'h55555555, 5'd9);
      req_valid = 1'b0;
      step();
      chk("fadd_x1_hold", fpu_x1, 32'h3F800000);
      chk("fadd_x2_hold", fpu_x2, 32'h40000000);
      chk("fadd_not_yet", {31'd0, resp_valid}, 32'd0);
      step();
      chk("fadd_valid", {31'd0, resp_valid}, 32'd1);
      chk("fadd_data", resp_data, 32'h40400000);
      chk("fadd_rd", {27'd0, resp_rd}, 32'd5);
      handshake();

      // Table-driven latency/result vectors
      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].x1, vecs[i].x2, vecs[i].rd);
         step();
         req_valid = 1'b0;
         lat = 0;
         while (!resp_valid && lat < 40) begin
            step();
            lat++;
         end
         exp_d = vecs[i].exp_err ? 32'd0 : fake_y(vecs[i].op, vecs[i].x1, vecs[i].x2);
         chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         chk($sformatf("vec%0d_data", i), resp_data, exp_d);
         chk($sformatf("vec%0d_rd", i), {27'd0, resp_rd}, {27'd0, vecs[i].rd});
         chk($sformatf("vec%0d_err", i), {31'd0, resp_err}, {31'd0, vecs[i].exp_err});
         handshake();
      end

      // feq zero latency, held response, one bubble before next accept
      drive(4'd8, 32'h00001234, 32'h00001234, 5'd7);
      step();
      chk("feq_valid", {31'd0, resp_valid}, 32'd1);
      chk("feq_data", resp_data, 32'd1);
      drive(4'd2, 32'h00000005, 32'h00000007, 5'd9);
      repeat (3) step();
      chk("feq_hold_data", resp_data, 32'd1);
      chk("feq_hold_rd", {27'd0, resp_rd}, 32'd7);
      handshake();
      chk("bubble_ready", {31'd0, req_ready}, 32'd1);
      chk("bubble_idle", {31'd0, busy}, 32'd0);
      step();
      chk("after_bubble_busy", {31'd0, busy}, 32'd1);
      req_valid = 1'b0;
      step();
      chk("fmul_after_feq", {31'd0, resp_valid}, 32'd1);
      handshake();

      // fdiv flushed at cycle 4, then fmul
      drive(4'd3, 32'h40A00000, 32'h40000000, 5'd12);
      step();
      req_valid = 1'b0;
      repeat (3) step();
      flush = 1'b1;
      drive(4'd2, 32'h00000002, 32'h00000003, 5'd13);
      #1;
      chk("flush_ready_low", {31'd0, req_ready}, 32'd0);
      step();
      flush = 1'b0; req_valid = 1'b0;
      chk("flush_idle", {31'd0, busy}, 32'd0);
      repeat (12) step();
      drive(4'd2, 32'h00000002, 32'h00000003, 5'd13);
      step();
      req_valid = 1'b0;
      step();
      chk("post_flush_fmul", {31'd0, resp_valid}, 32'd1);
      chk("post_flush_rd", {27'd0, resp_rd}, 32'd13);
      handshake();

      // Illegal op
      drive(4'd14, 32'hCAFEF00D, 32'h0BADBEEF, 5'd3);
      step();
      req_valid = 1'b0;
      chk("ill_err", {31'd0, resp_err}, 32'd1);
      chk("ill_data", resp_data, 32'd0);
      chk("ill_rd", {27'd0, resp_rd}, 32'd3);
      handshake();
      chk("ill_err_clear", {31'd0, resp_err}, 32'd0);

      // Reset mid-fdiv with counter at 6
      drive(4'd3, 32'h41200000, 32'h40000000, 5'd21);
      step();
      req_valid = 1'b0;
      repeat (4) step();
      rstn = 1'b0;
      #1;
      model_reset();
      chk("rst_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_data", resp_data, 32'd0);
      chk("rst_rd", {27'd0, resp_rd}, 32'd0);
      chk("rst_err", {31'd0, resp_err}, 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      repeat (15) step();

      // Random traffic against the model and scoreboard
      for (int c = 0; c < 2000; c++) begin
         req_valid  = ($urandom_range(0, 1) == 1);
         req_op     = 4'($urandom_range(0, 15));
         req_x1     = $urandom;
         req_x2     = ($urandom_range(0, 7) == 0) ? req_x1 : $urandom;
         req_rd     = 5'($urandom_range(0, 31));
         resp_ready = ($urandom_range(0, 9) < 6);
         flush      = ($urandom_range(0, 49) == 0);
         step();
      end
      req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
      repeat (15) step();
      chk("drain_empty", sb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
